// File: rtl/chip8_fetch_ctrl.sv
// CHIP-8 instruction fetch sequencer: reads two opcode bytes at pc over a shared
// single-port byte memory and hands the big-endian opcode to the decoder.
module chip8_fetch_ctrl #(
  parameter int ADDR_W = 12
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [15:0]       pc,
  output logic              pc_advance,
  input  logic              redirect,
  input  logic              halt,
  output logic              op_valid,
  output logic [15:0]       op,
  input  logic              op_ready,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_re,
  output logic              mem_we,
  output logic [7:0]        mem_wdata,
  input  logic [7:0]        mem_rdata,
  input  logic              dreq_valid,
  input  logic              dreq_we,
  input  logic [ADDR_W-1:0] dreq_addr,
  input  logic [7:0]        dreq_wdata,
  output logic              dreq_ready,
  output logic              dresp_valid,
  output logic [7:0]        dresp_data,
  output logic [1:0]        state_dbg
);

  // Handshakes: op transfers on a cycle with op_valid && op_ready; a data request
  // completes on a cycle with dreq_valid && dreq_ready; dresp_valid is a one-cycle pulse.

  typedef enum logic [1:0] {F_HI, F_LO, F_CAP, HOLD} state_t;

  state_t      state, state_nxt;
  logic [15:0] op_q;
  logic        rd_pend;
  logic        unused_pc_hi;

  assign unused_pc_hi = &{1'b0, pc[15:ADDR_W]};

  always_comb begin
    state_nxt  = state;
    pc_advance = 1'b0;
    mem_re     = 1'b0;
    mem_we     = 1'b0;
    mem_addr   = '0;
    mem_wdata  = 8'h00;
    dreq_ready = 1'b0;
    case (state)
      F_HI: begin
        if (dreq_valid) begin
          dreq_ready = 1'b1;
        end else if (!halt && !redirect) begin
          mem_re    = 1'b1;
          mem_addr  = pc[ADDR_W-1:0];
          state_nxt = F_LO;
        end
      end
      F_LO: begin
        if (redirect) begin
          state_nxt = F_HI;
        end else begin
          mem_re    = 1'b1;
          mem_addr  = pc[ADDR_W-1:0] + ADDR_W'(1);
          state_nxt = F_CAP;
        end
      end
      F_CAP: state_nxt = redirect ? F_HI : HOLD;
      HOLD: begin
        dreq_ready = dreq_valid;
        if (redirect) begin
          state_nxt = F_HI;
        end else if (op_ready) begin
          pc_advance = 1'b1;
          state_nxt  = F_HI;
        end
      end
      default: state_nxt = F_HI;
    endcase
    // A granted data request owns the port; fetch never issues in the same cycle.
    if (dreq_ready) begin
      mem_addr  = dreq_addr;
      mem_we    = dreq_we;
      mem_re    = !dreq_we;
      mem_wdata = dreq_we ? dreq_wdata : 8'h00;
    end
    if (rst) begin
      state_nxt  = F_HI;
      pc_advance = 1'b0;
      mem_re     = 1'b0;
      mem_we     = 1'b0;
      mem_addr   = '0;
      mem_wdata  = 8'h00;
      dreq_ready = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= F_HI;
      op_q    <= 16'h0000;
      rd_pend <= 1'b0;
    end else begin
      state   <= state_nxt;
      rd_pend <= dreq_ready && !dreq_we;
      if (state == F_LO && !redirect)  op_q[15:8] <= mem_rdata;
      if (state == F_CAP && !redirect) op_q[7:0]  <= mem_rdata;
    end
  end

  assign op_valid    = (state == HOLD);
  assign op          = op_q;
  assign dresp_valid = rd_pend;
  assign dresp_data  = rd_pend ? mem_rdata : 8'h00;
  assign state_dbg   = state;

endmodule

// File: tb/tb_chip8_fetch_ctrl.sv
// Directed bench for chip8_fetch_ctrl with a byte memory and a PC unit model.
module tb_chip8_fetch_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] pc;
  logic        pc_advance;
  logic        redirect;
  logic [15:0] redir_pc;
  logic        halt;
  logic        op_valid;
  logic [15:0] op;
  logic        op_ready;
  logic [11:0] mem_addr;
  logic        mem_re, mem_we;
  logic [7:0]  mem_wdata, mem_rdata;
  logic        dreq_valid, dreq_we;
  logic [11:0] dreq_addr;
  logic [7:0]  dreq_wdata;
  logic        dreq_ready, dresp_valid;
  logic [7:0]  dresp_data;
  logic [1:0]  state_dbg;
  logic [7:0]  mem [0:4095];

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  chip8_fetch_ctrl #(.ADDR_W(12)) dut (
    .clk(clk), .rst(rst), .pc(pc), .pc_advance(pc_advance), .redirect(redirect),
    .halt(halt), .op_valid(op_valid), .op(op), .op_ready(op_ready),
    .mem_addr(mem_addr), .mem_re(mem_re), .mem_we(mem_we), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .dreq_valid(dreq_valid), .dreq_we(dreq_we),
    .dreq_addr(dreq_addr), .dreq_wdata(dreq_wdata), .dreq_ready(dreq_ready),
    .dresp_valid(dresp_valid), .dresp_data(dresp_data), .state_dbg(state_dbg)
  );

  // Byte memory with 1-cycle read latency; contents are loaded during reset.
  always @(posedge clk) begin
    if (rst) begin
      mem[12'h070] <= 8'h12; mem[12'h071] <= 8'h34;
      mem[12'hFFF] <= 8'hA2; mem[12'h000] <= 8'h2A;
      mem[12'h200] <= 8'h55;
      mem[12'h300] <= 8'h60; mem[12'h301] <= 8'h0A;
      mem[12'h302] <= 8'h81; mem[12'h303] <= 8'h23;
      mem_rdata    <= 8'h00;
    end else begin
      if (mem_re) mem_rdata <= mem[mem_addr];
      if (mem_we) mem[mem_addr] <= mem_wdata;
    end
  end

  // PC unit: loads on redirect, otherwise pc+2 on pc_advance.
  always @(posedge clk) begin
    if (rst)             pc <= 16'h0000;
    else if (redirect)   pc <= redir_pc;
    else if (pc_advance) pc <= pc + 16'd2;
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  initial begin
    rst = 1'b1; redirect = 1'b0; redir_pc = 16'h0; halt = 1'b0; op_ready = 1'b1;
    dreq_valid = 1'b1; dreq_we = 1'b0; dreq_addr = 12'h0; dreq_wdata = 8'h0;
    tick; tick; #1;
    chk("rst_op_valid", 16'(op_valid), 16'h0);
    chk("rst_op", op, 16'h0000);
    chk("rst_mem_re", 16'(mem_re), 16'h0);
    chk("rst_mem_we", 16'(mem_we), 16'h0);
    chk("rst_dreq_ready", 16'(dreq_ready), 16'h0);
    chk("rst_pc_advance", 16'(pc_advance), 16'h0);
    chk("rst_dresp", {7'(0), dresp_valid, dresp_data}, 16'h0);
    chk("rst_state", 16'(state_dbg), 16'h0);

    // Load pc=0x070 while idle in F_HI.
    tick; rst = 1'b0; dreq_valid = 1'b0; redirect = 1'b1; redir_pc = 16'h0070; #1;
    chk("redir_idle_re", 16'(mem_re), 16'h0);
    tick; redirect = 1'b0; #1;                                   // cycle 0
    chk("c0_re", 16'(mem_re), 16'h1);
    chk("c0_addr", 16'(mem_addr), 16'h070);
    tick; #1;                                                    // cycle 1
    chk("c1_addr", 16'(mem_addr), 16'h071);
    tick; #1;                                                    // cycle 2
    chk("c2_op_valid", 16'(op_valid), 16'h0);
    tick; #1;                                                    // cycle 3
    chk("c3_op_valid", 16'(op_valid), 16'h1);
    chk("c3_op", op, 16'h1234);
    chk("c3_pc_advance", 16'(pc_advance), 16'h1);
    tick; #1;                                                    // cycle 4: next fetch
    chk("c4_addr", 16'(mem_addr), 16'h072);

    // Wrap-around fetch at 0xFFF.
    tick; redirect = 1'b1; redir_pc = 16'h0FFF; #1;
    tick; redirect = 1'b0; #1;
    chk("wrap_addr_hi", 16'(mem_addr), 16'hFFF);
    tick; #1;
    chk("wrap_addr_lo", 16'(mem_addr), 16'h000);
    chk("wrap_re_lo", 16'(mem_re), 16'h1);
    tick; #1;
    tick; #1;
    chk("wrap_op", op, 16'hA22A);
    chk("wrap_valid", 16'(op_valid), 16'h1);

    // Data read held for two cycles in F_HI; pc reloaded to 0x070 meanwhile.
    tick; dreq_valid = 1'b1; dreq_we = 1'b0; dreq_addr = 12'h200;
    redirect = 1'b1; redir_pc = 16'h0070; #1;
    chk("dr0_ready", 16'(dreq_ready), 16'h1);
    chk("dr0_addr", 16'(mem_addr), 16'h200);
    chk("dr0_re", 16'(mem_re), 16'h1);
    tick; redirect = 1'b0; #1;
    chk("dr1_ready", 16'(dreq_ready), 16'h1);
    chk("dr1_resp", {7'(0), dresp_valid, dresp_data}, 16'h0155);
    tick; dreq_valid = 1'b0; #1;
    chk("dr2_resp", {7'(0), dresp_valid, dresp_data}, 16'h0155);
    chk("dr2_fetch_addr", 16'(mem_addr), 16'h070);
    chk("dr2_fetch_re", 16'(mem_re), 16'h1);
    tick; dreq_valid = 1'b1; #1;                                 // F_LO: no grant
    chk("flo_no_grant", 16'(dreq_ready), 16'h0);
    chk("flo_resp_clear", 16'(dresp_valid), 16'h0);

    // Redirect in F_CAP to 0x300.
    tick; dreq_valid = 1'b0; redirect = 1'b1; redir_pc = 16'h0300; #1;
    chk("rd_cap_valid", 16'(op_valid), 16'h0);
    chk("rd_cap_adv", 16'(pc_advance), 16'h0);
    tick; redirect = 1'b0; #1;
    chk("rd_next_valid", 16'(op_valid), 16'h0);
    chk("rd_next_addr", 16'(mem_addr), 16'h300);
    chk("rd_next_adv", 16'(pc_advance), 16'h0);
    tick; #1;
    tick; #1;
    tick; #1;
    chk("rd_op", op, 16'h600A);
    chk("rd_adv", 16'(pc_advance), 16'h1);

    // Halt for 10 cycles in F_HI.
    for (int i = 0; i < 10; i++) begin
      tick; halt = 1'b1; #1;
      chk("halt_re", 16'(mem_re), 16'h0);
      chk("halt_valid", 16'(op_valid), 16'h0);
    end
    tick; halt = 1'b0; #1;
    chk("unhalt_addr", 16'(mem_addr), 16'h302);
    tick; #1;
    tick; #1;
    chk("unhalt_c2_valid", 16'(op_valid), 16'h0);

    // Hold with op_ready low for 5 cycles, data write granted meanwhile.
    tick; op_ready = 1'b0; #1;
    chk("hold_valid", 16'(op_valid), 16'h1);
    chk("hold_op", op, 16'h8123);
    chk("hold_adv", 16'(pc_advance), 16'h0);
    tick; dreq_valid = 1'b1; dreq_we = 1'b1; dreq_addr = 12'h300; dreq_wdata = 8'h77; #1;
    chk("hold_wr_ready", 16'(dreq_ready), 16'h1);
    chk("hold_wr_we", 16'(mem_we), 16'h1);
    chk("hold_wr_re", 16'(mem_re), 16'h0);
    chk("hold_wr_addr", 16'(mem_addr), 16'h300);
    chk("hold_wr_data", 16'(mem_wdata), 16'h77);
    for (int i = 0; i < 3; i++) begin
      tick; dreq_valid = 1'b0; dreq_we = 1'b0; #1;
      chk("hold_op_stable", op, 16'h8123);
      chk("hold_valid_stable", 16'(op_valid), 16'h1);
      chk("hold_no_adv", 16'(pc_advance), 16'h0);
      chk("hold_idle_addr", 16'(mem_addr), 16'h000);
    end
    tick; op_ready = 1'b1; #1;
    chk("hold_accept_adv", 16'(pc_advance), 16'h1);
    chk("hold_accept_op", op, 16'h8123);

    // Read back the written byte, then fetch from 0x304.
    tick; dreq_valid = 1'b1; dreq_addr = 12'h300; #1;
    chk("rb_addr", 16'(mem_addr), 16'h300);
    tick; dreq_valid = 1'b0; #1;
    chk("rb_resp", {7'(0), dresp_valid, dresp_data}, 16'h0177);
    chk("rb_fetch_addr", 16'(mem_addr), 16'h304);

    // Reset mid-fetch.
    tick; rst = 1'b1; #1;
    chk("mid_rst_re", 16'(mem_re), 16'h0);
    tick; rst = 1'b0; #1;
    chk("post_rst_state", 16'(state_dbg), 16'h0);
    chk("post_rst_valid", 16'(op_valid), 16'h0);
    chk("post_rst_op", op, 16'h0000);
    chk("post_rst_resp", 16'(dresp_valid), 16'h0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL timeout: observed running expected finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/chip8_fetch_ctrl.md
# chip8_fetch_ctrl

Sequencer for instruction fetch in the CHIP-8 core. Reads the two opcode bytes at the program counter from a shared single-port byte memory and assembles them big-endian into a 16-bit opcode. Presents the opcode to the decoder with a valid/ready handshake and pulses the PC unit's advance input on acceptance. Shares the memory port with the execute unit's byte load/store requests: data requests take priority at fetch boundaries, and a started fetch pair is never split.

## Interface
- ADDR_W, 12, memory byte-address width (4 KiB)
- clk  in  1  clock
- rst  in  1  synchronous, active-high reset
- pc  in  16  current program counter from PC unit; low ADDR_W bits used
- pc_advance  out  1  combinational pulse; PC unit does pc+2 at this edge
- redirect  in  1  branch/offset taken this cycle; aborts in-flight fetch
- halt  in  1  key-wait; blocks start of a new fetch
- op_valid  out  1  opcode available
- op  out  16  opcode, {byte[pc], byte[pc+1]}
- op_ready  in  1  decoder accepts op
- mem_addr  out  ADDR_W  memory address
- mem_re  out  1  read strobe; mem_rdata valid next cycle
- mem_we  out  1  write strobe
- mem_wdata  out  8  write data
- mem_rdata  in  8  read data, 1-cycle latency
- dreq_valid  in  1  execute-unit data request
- dreq_we  in  1  1 = write, 0 = read
- dreq_addr  in  ADDR_W  data address
- dreq_wdata  in  8  write data
- dreq_ready  out  1  combinational grant; request completes this cycle
- dresp_valid  out  1  read data valid, one cycle after a read grant
- dresp_data  out  8  read data

## Operation
- States:
  - F_HI: issue pc
  - F_LO: capture hi byte, issue pc+1
  - F_CAP: capture lo byte, set op_valid
  - HOLD: op_valid=1, wait for op_ready
- F_HI:
  - if dreq_valid: grant data (dreq_ready=1, port carries data request); stay in F_HI.
  - else if !halt && !redirect: mem_re=1, mem_addr=pc; go to F_LO.
  - else: stay in F_HI.
- F_LO: mem_re=1, mem_addr=pc+1 (mod 2^ADDR_W, so 0xFFF+1 = 0x000); latch mem_rdata to op[15:8]; go to F_CAP.
- F_CAP: latch mem_rdata to op[7:0]; set op_valid; go to HOLD.
- HOLD:
  - if dreq_valid: grant data; the port is idle in this state.
  - if op_ready: pc_advance = !redirect; clear op_valid; go to F_HI.
- dreq_ready=0 in F_LO and F_CAP.
- A granted read sets dresp_valid=1 and dresp_data=mem_rdata the next cycle.
- A granted write drives mem_we=1, mem_addr=dreq_addr and mem_wdata=dreq_wdata in the grant cycle.
- redirect in F_LO, F_CAP or HOLD:
  - discard partial/held opcode; op_valid=0 next cycle; go to F_HI.
  - pc_advance=0 that cycle; the PC unit loads the new value at the same edge.
- halt does not affect F_LO, F_CAP or HOLD; it only blocks leaving F_HI.
- Unused outputs are driven to 0: mem_addr and mem_wdata when the port is idle.

## Timing
- Reset values:
  - state F_HI
  - op_valid=0, op=0x0000
  - pc_advance=0, mem_re=0, mem_we=0, dreq_ready=0
  - dresp_valid=0, dresp_data=0
- rst overrides everything, including mid-fetch and mid-HOLD; the response in flight is dropped.
- Fetch latency: F_HI at cycle T gives op_valid high at T+3 with no data contention.
- Throughput: with op_ready tied high, one opcode every 4 cycles.
- pc_advance is asserted only in the cycle of the HOLD accept handshake; the next F_HI samples the updated pc.
- op is stable while op_valid=1.
- Each cycle in F_HI with dreq_valid=1 delays the fetch by one cycle.

## Test plan
- mem[0x070]=0x12, mem[0x071]=0x34, pc=0x0070, op_ready=1, no data requests -> op=0x1234 and op_valid at cycle 3; pc_advance pulses at cycle 3.
- pc=0x0FFF, mem[0xFFF]=0xA2, mem[0x000]=0x2A -> op=0xA22A; mem_addr sequence 0xFFF then 0x000.
- dreq_valid read of 0x200 (=0x55) held for 2 cycles in F_HI -> two grants, dresp_data=0x55 each following cycle; fetch starts on cycle 2.
- redirect pulsed in F_CAP while pc is loaded to 0x0300 -> no op_valid for the old pc; the next op is fetched from 0x300 and pc_advance never fires for the aborted fetch.
- halt=1 in F_HI for 10 cycles -> mem_re=0 and op_valid=0 throughout; after halt falls, op_valid rises 3 cycles later.
- op_ready=0 for 5 cycles in HOLD with a write to 0x300 (0x77) -> op held constant, write granted, pc_advance=0 until op_ready.
